// File: rtl/apb_master_bridge.sv
// APB3 initiator: converts single-beat valid/ready requests into SETUP/ACCESS transfers
// and returns read data / error status on a valid/ready response channel.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen during the last ACCESS cycle allowed before abort
  localparam logic [CNT_W-1:0] LAST_WAIT = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [31:0]               pwdata_d;
  logic                      pwrite_d;
  logic [31:0]               rsp_rdata_d;
  logic                      rsp_err_d;
  logic                      rsp_timeout_d;

  // Next-state and next-payload decode
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pwrite_d      = PWRITE;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d    = req_addr;
          pwdata_d   = req_wdata;
          pwrite_d   = req_write;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d   = PWRITE ? 32'd0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q == LAST_WAIT)) begin
          rsp_rdata_d   = 32'd0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; control strobes are decoded from the next state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PWRITE      <= pwrite_d;
      PSEL        <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      PENABLE     <= (state_d == ST_ACCESS);
      req_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      rsp_valid   <= (state_d == ST_RESP);
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT_CYCLES=4): zero-wait, wait states,
// slave error, timeout, response backpressure and mid-transfer reset.
module tb_apb_master_bridge;

  localparam int unsigned AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    tests++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin fails++;
      $display("FAIL rst_psel_penable: got %b%b exp 00", PSEL, PENABLE); end
    tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin fails++;
      $display("FAIL rst_rsp_flags: got %b%b%b exp 000", rsp_valid, rsp_err, rsp_timeout); end
    tests++; if (PADDR !== 12'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || PWRITE !== 1'b0) begin fails++;
      $display("FAIL rst_data: paddr %h pwdata %h rdata %h pwrite %b exp zeros", PADDR, PWDATA, rsp_rdata, PWRITE); end
    tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL rst_ready_busy: got %b%b exp 10", req_ready, busy); end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    PRDATA = 32'hFFFF_FFFF; PREADY = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'h004; req_write = 1'b1; req_wdata = 32'h0000_0012;
    tick();  // cycle 1: SETUP
    req_valid = 1'b0; req_wdata = 32'h0;
    tests++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin fails++;
      $display("FAIL wr_setup: psel/penable got %b%b exp 10", PSEL, PENABLE); end
    tests++; if (PADDR !== 12'h004 || PWRITE !== 1'b1 || PWDATA !== 32'h12) begin fails++;
      $display("FAIL wr_addr_data: got %h %b %h exp 004 1 00000012", PADDR, PWRITE, PWDATA); end
    tests++; if (req_ready !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL wr_busy: ready/busy got %b%b exp 01", req_ready, busy); end
    tick();  // cycle 2: ACCESS
    tests++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
      $display("FAIL wr_access: psel/penable/rspv got %b%b%b exp 110", PSEL, PENABLE, rsp_valid); end
    tick();  // cycle 3: RESP
    tests++; if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin fails++;
      $display("FAIL wr_resp: rspv/psel/penable got %b%b%b exp 100", rsp_valid, PSEL, PENABLE); end
    tests++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin fails++;
      $display("FAIL wr_payload: rdata %h err %b to %b exp 0 0 0", rsp_rdata, rsp_err, rsp_timeout); end
    tick();  // cycle 4: IDLE again
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL wr_idle: ready/rspv/busy got %b%b%b exp 100", req_ready, rsp_valid, busy); end
  endtask

  task automatic test_read_wait_states();
    PRDATA = 32'hDEAD_BEEF; PREADY = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'h020; req_write = 1'b0; req_wdata = 32'h5555_5555;
    tick();  // SETUP
    req_valid = 1'b0; req_addr = 12'hFFF;
    // PREADY low in ACCESS cycles 1..3, high in cycle 4 (the last cycle before timeout)
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 12'h020 || PWRITE !== 1'b0) begin fails++;
        $display("FAIL rd_access%0d: psel %b pen %b paddr %h pwrite %b exp 1 1 020 0", i, PSEL, PENABLE, PADDR, PWRITE); end
      PREADY = (i == 4);
    end
    tick();  // RESP
    PREADY = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin fails++;
      $display("FAIL rd_data: rspv %b rdata %h exp 1 deadbeef", rsp_valid, rsp_rdata); end
    tests++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin fails++;
      $display("FAIL rd_status: err %b to %b exp 0 0", rsp_err, rsp_timeout); end
    tick();
  endtask

  task automatic test_slverr();
    PREADY = 1'b1; PSLVERR = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'h008; req_write = 1'b1; req_wdata = 32'h0000_00A5;
    tick(); req_valid = 1'b0;
    tick();
    tick();  // RESP
    PSLVERR = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin fails++;
      $display("FAIL slverr_rsp: rspv %b err %b to %b rdata %h exp 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();  // IDLE
    tests++; if (req_ready !== 1'b1) begin fails++;
      $display("FAIL slverr_idle: req_ready %b exp 1", req_ready); end
    req_valid = 1'b1; req_addr = 12'h00C; req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    tests++; if (PSEL !== 1'b1 || PADDR !== 12'h00C || busy !== 1'b1) begin fails++;
      $display("FAIL slverr_next_accept: psel %b paddr %h busy %b exp 1 00c 1", PSEL, PADDR, busy); end
    tick(); tick(); tick();  // ACCESS, RESP, IDLE
  endtask

  task automatic test_timeout();
    int acc_cycles;
    int guard;
    PREADY = 1'b0; PRDATA = 32'hCAFE_F00D; rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'h030; req_write = 1'b0;
    tick(); req_valid = 1'b0;
    acc_cycles = 0;
    guard = 0;
    tick();
    while (rsp_valid !== 1'b1 && guard < 20) begin
      if (PENABLE === 1'b1) acc_cycles++;
      tick();
      guard++;
    end
    tests++; if (rsp_valid !== 1'b1) begin fails++;
      $display("FAIL to_no_rsp: rsp_valid %b after %0d cycles exp 1", rsp_valid, guard); end
    tests++; if (acc_cycles != 4) begin fails++;
      $display("FAIL to_access_len: got %0d cycles exp 4", acc_cycles); end
    tests++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 1'b0) begin fails++;
      $display("FAIL to_status: err %b to %b rdata %h psel %b exp 1 1 0 0", rsp_err, rsp_timeout, rsp_rdata, PSEL); end
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure_reset();
    PREADY = 1'b1; PRDATA = 32'h1234_5678; rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'h010; req_write = 1'b0;
    tick(); req_valid = 1'b0;
    tick();
    tick();  // RESP, stalled
    PRDATA = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin fails++;
        $display("FAIL bp_hold%0d: rspv %b rdata %h err %b rdy %b exp 1 12345678 0 0", i, rsp_valid, rsp_rdata, rsp_err, req_ready); end
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
      $display("FAIL bp_release: rspv %b rdy %b exp 0 1", rsp_valid, req_ready); end
    PREADY = 1'b0;
    req_valid = 1'b1; req_addr = 12'h03C; req_write = 1'b1; req_wdata = 32'h7777_7777;
    tick(); req_valid = 1'b0;
    tick();  // ACCESS
    tests++; if (PENABLE !== 1'b1) begin fails++;
      $display("FAIL rst_pre_access: penable %b exp 1", PENABLE); end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    tests++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || PADDR !== 12'h0) begin fails++;
      $display("FAIL rst_mid: psel %b pen %b busy %b rdy %b paddr %h exp 0 0 0 1 000", PSEL, PENABLE, busy, req_ready, PADDR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin fails++;
        $display("FAIL rst_no_rsp%0d: rspv %b psel %b exp 0 0", i, rsp_valid, PSEL); end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slverr();
    test_timeout();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
